// File: rtl/layer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_sched_pkg
// Brief    : Shared types, default sizes and lane helper for layer_sched.
// Revision : 1.0 - initial release
// ============================================================================
package layer_sched_pkg;

    localparam int c_lanes  = 9;
    localparam int c_data_w = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // Lane 0 (the first array lane) lives in the LSBs of the packed word.
    function automatic logic [c_data_w-1:0] lane_slice(
        input logic [c_lanes*c_data_w-1:0] vec,
        input int unsigned                 lane
    );
        return vec[lane*c_data_w +: c_data_w];
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_sched_wdog.sv
`default_nettype none
// ============================================================================
// Module   : layer_sched_wdog
// Brief    : RUN-phase watchdog counter with clear, enable and expired flag.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sched_wdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_cnt_w = $clog2(TIMEOUT) + 1;

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Count equals the number of RUN cycles already completed, so the flag
    // rises during the TIMEOUT-th RUN cycle.
    assign o_expired = (r_cnt == c_cnt_w'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : layer_sched
// Brief    : Job sequencer for the 9-lane systolic dense layer array.
//            Optional macro LAYER_SCHED_RELU_EN clamps negative lanes at capture.
// Revision : 1.0 - initial release
// ============================================================================
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int LANES   = c_lanes,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_W-1:0]       cmd_base,
    input  logic [CNT_W-1:0]        cmd_count,
    output logic [ADDR_W-1:0]       vec_addr,
    output logic                    arr_en,
    input  logic                    arr_done,
    input  logic [LANES*DATA_W-1:0] arr_res,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [LANES*DATA_W-1:0] res_data,
    output logic [CNT_W-1:0]        res_idx,
    output logic                    res_last,
    output logic                    job_done,
    output logic                    busy,
    output logic                    err
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_accept;
    logic                    w_capture;
    logic                    w_abort;
    logic                    w_handshake;
    logic                    w_wd_expired;
    logic [LANES*DATA_W-1:0] w_res_cap;

    logic [ADDR_W-1:0]       r_base;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        r_idx;
    logic [ADDR_W-1:0]       r_vec_addr;
    logic [LANES*DATA_W-1:0] r_res_data;
    logic [CNT_W-1:0]        r_res_idx;
    logic                    r_res_last;
    logic                    r_job_done;
    logic                    r_err;

    layer_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == S_LOAD),
        .i_en      (r_state == S_RUN),
        .o_expired (w_wd_expired)
    );

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] w_lane;
        assign w_lane = lane_slice(arr_res, gi);
`ifdef LAYER_SCHED_RELU_EN
        assign w_res_cap[gi*DATA_W +: DATA_W] = w_lane[DATA_W-1] ? '0 : w_lane;
`else
        assign w_res_cap[gi*DATA_W +: DATA_W] = w_lane;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_count != '0) begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN: begin
                // A result arriving on the last permitted cycle wins over abort.
                if (arr_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_wd_expired) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: w_state_nxt = S_OUT;
            S_OUT: begin
                if (res_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = r_res_last ? S_IDLE : S_LOAD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_vec_addr <= '0;
            r_res_data <= '0;
            r_res_idx  <= '0;
            r_res_last <= 1'b0;
            r_job_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_job_done <= 1'b0;
            if (w_accept) begin
                r_base     <= cmd_base;
                r_count    <= cmd_count;
                r_idx      <= '0;
                r_vec_addr <= cmd_base;
                r_err      <= 1'b0;
                if (cmd_count == '0) begin
                    r_job_done <= 1'b1;
                end
            end
            if (w_capture) begin
                r_res_data <= w_res_cap;
                r_res_idx  <= r_idx;
                r_res_last <= (r_idx == r_count - CNT_W'(1));
            end
            if (w_abort) begin
                r_err      <= 1'b1;
                r_job_done <= 1'b1;
            end
            if (w_handshake) begin
                if (r_res_last) begin
                    r_job_done <= 1'b1;
                end else begin
                    r_idx      <= r_idx + CNT_W'(1);
                    r_vec_addr <= r_base + ADDR_W'(r_idx + CNT_W'(1));
                end
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign arr_en    = (r_state == S_RUN);
    assign res_valid = (r_state == S_OUT);
    assign vec_addr  = r_vec_addr;
    assign res_data  = r_res_data;
    assign res_idx   = r_res_idx;
    assign res_last  = r_res_last;
    assign job_done  = r_job_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_layer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_layer_sched
// Brief    : Scoreboard bench for layer_sched with a behavioural array/buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sched;

    localparam int DATA_W  = 16;
    localparam int LANES   = 9;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 32;
    localparam int RW      = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [CNT_W-1:0]  cmd_count = '0;
    logic [ADDR_W-1:0] vec_addr;
    logic              arr_en;
    logic              arr_done;
    logic [RW-1:0]     arr_res;
    logic              res_valid;
    logic              res_ready;
    logic [RW-1:0]     res_data;
    logic [CNT_W-1:0]  res_idx;
    logic              res_last;
    logic              job_done;
    logic              busy;
    logic              err;

    layer_sched #(
        .DATA_W (DATA_W), .LANES (LANES), .ADDR_W (ADDR_W),
        .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_base (cmd_base), .cmd_count (cmd_count),
        .vec_addr (vec_addr), .arr_en (arr_en),
        .arr_done (arr_done), .arr_res (arr_res),
        .res_valid (res_valid), .res_ready (res_ready),
        .res_data (res_data), .res_idx (res_idx), .res_last (res_last),
        .job_done (job_done), .busy (busy), .err (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] data;
        logic [7:0]    idx;
        logic          last;
    } res_t;

    res_t          res_q[$];
    logic [7:0]    addr_q[$];
    logic [RW-1:0] buf_mem [256];
    logic [RW-1:0] last_data;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            lat      = 13;   // 0 = array never finishes
    int            rdy_mode = 0;    // 0 always, 1 random, 2 ten-cycle stall
    int            en_rises = 0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[RW-1:0];
    endfunction

    // Reference capture: optionally clamp every negative signed lane to zero.
    function automatic logic [RW-1:0] ref_capture(input logic [RW-1:0] v);
        logic [RW-1:0] r;
        r = v;
`ifdef LAYER_SCHED_RELU_EN
        for (int k = 0; k < LANES; k++) begin
            if ($signed(v[k*DATA_W +: DATA_W]) < 0) r[k*DATA_W +: DATA_W] = '0;
        end
`endif
        return r;
    endfunction

    // Behavioural array: done on the lat-th enabled cycle, results from the
    // buffer word at vec_addr; done toggles randomly while disabled.
    initial begin
        int en_cnt;
        en_cnt   = 0;
        arr_done = 1'b0;
        arr_res  = '0;
        forever begin
            @(posedge clk); #1;
            if (arr_en) begin
                en_cnt++;
                arr_done = (lat != 0) && (en_cnt == lat);
            end else begin
                en_cnt   = 0;
                arr_done = 1'($urandom_range(0, 1));
            end
            arr_res = (arr_done && arr_en) ? buf_mem[vec_addr] : rand_word();
        end
    end

    initial begin
        int stall_n;
        stall_n   = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) begin
                res_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                res_ready = 1'($urandom_range(0, 1));
            end else if (res_valid && stall_n < 10) begin
                res_ready = 1'b0;
                stall_n++;
            end else begin
                res_ready = 1'b1;
                if (!res_valid) stall_n = 0;
            end
        end
    end

    // Monitor: run starts, backpressure stability and result scoreboard.
    initial begin
        logic          prev_stall, prev_en;
        logic [RW-1:0] pd;
        logic [7:0]    pi, pa;
        res_t          e;
        prev_stall = 1'b0;
        prev_en    = 1'b0;
        pd = '0; pi = '0; pa = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_en    = 1'b0;
            end else begin
                if (arr_en && !prev_en) begin
                    en_rises++;
                    if (addr_q.size() == 0) chk("unexpected_run", 1, 0);
                    else chk("vec_addr", vec_addr, addr_q.pop_front());
                end
                if (prev_stall) begin
                    chk("bp_valid", res_valid, 1);
                    chk("bp_data", res_data, pd);
                    chk("bp_idx", res_idx, pi);
                    chk("bp_arr_en", arr_en, 0);
                    chk("bp_vec_addr", vec_addr, pa);
                end
                if (res_valid && res_ready) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = res_q.pop_front();
                        chk("res_data", res_data, e.data);
                        chk("res_idx", res_idx, e.idx);
                        chk("res_last", res_last, e.last);
                        last_data = res_data;
                    end
                end
                prev_stall = res_valid && !res_ready;
                prev_en    = arr_en;
                pd = res_data; pi = res_idx; pa = vec_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_job(input logic [7:0] base, input logic [7:0] cnt, input int mode, input int l);
        bit to;
        int delta, exp_delta, rises0, exp_rises;
        lat      = l;
        rdy_mode = mode;
        to       = (l == 0 || l > TIMEOUT) && cnt != 0;
        for (int i = 0; i < cnt; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            addr_q.push_back(a);
            if (to) break;
            res_q.push_back('{data: ref_capture(buf_mem[a]), idx: 8'(i), last: (i == cnt - 1)});
        end
        exp_rises = (cnt == 0) ? 0 : (to ? 1 : int'(cnt));
        exp_delta = (cnt == 0) ? 0 : (to ? TIMEOUT + 1 : int'(cnt) * (16 + (mode == 2 ? 10 : 0)));
        rises0 = en_rises;
        delta  = 0;
        while (!cmd_ready && delta < 200) begin step(); delta++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_base = base; cmd_count = cnt;
        step();
        cmd_valid = 1'b0;
        chk("err_cleared", err, 0);
        chk("busy_after_accept", busy, cnt != 0);
        delta = 0;
        while (!job_done && delta < 3000) begin step(); delta++; end
        chk("job_done_seen", job_done, 1);
        if (mode != 1) chk("job_latency", delta, exp_delta);
        chk("err_end", err, to);
        chk("cmd_ready_end", cmd_ready, 1);
        chk("busy_end", busy, 0);
        chk("results_left", res_q.size(), 0);
        chk("runs_left", addr_q.size(), 0);
        chk("run_count", en_rises - rises0, exp_rises);
        step();
        chk("job_done_pulse", job_done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_arr_en"}, arr_en, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
        chk({tag, "_res_last"}, res_last, 0);
        chk({tag, "_vec_addr"}, vec_addr, 0);
        chk({tag, "_job_done"}, job_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [RW-1:0] w;
        int            runc, pulses;
        logic [15:0]   exp_l3;
        for (int a = 0; a < 256; a++) buf_mem[a] = rand_word();
        w = buf_mem[8'h40];
        w[2*DATA_W +: DATA_W] = 16'hFF00;
        w[3*DATA_W +: DATA_W] = 16'h0042;
        buf_mem[8'h40] = w;

        rst = 1'b1;
        step(); step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();
        chk("cmd_ready_after_reset", cmd_ready, 1);

        run_job(8'h10, 8'd3, 0, 13);
        run_job(8'h22, 8'd0, 0, 13);
        run_job(8'h30, 8'd2, 2, 13);
        run_job(8'h50, 8'd3, 0, 0);
        run_job(8'h40, 8'd1, 0, 13);
`ifdef LAYER_SCHED_RELU_EN
        exp_l3 = 16'h0000;
`else
        exp_l3 = 16'hFF00;
`endif
        chk("relu_lane3", last_data[2*DATA_W +: DATA_W], exp_l3);
        chk("relu_lane4", last_data[3*DATA_W +: DATA_W], 16'h0042);
        run_job(8'hFE, 8'd4, 0, 13);
        for (int j = 0; j < 6; j++) begin
            run_job(8'($urandom_range(0, 255)), 8'($urandom_range(1, 4)), $urandom_range(0, 2), 13);
        end

        // Reset during the fifth RUN cycle of the first vector.
        lat = 13; rdy_mode = 0;
        addr_q.push_back(8'h20);
        cmd_valid = 1'b1; cmd_base = 8'h20; cmd_count = 8'd2;
        step();
        cmd_valid = 1'b0;
        runc = 0;
        while (runc < 5 && runc >= 0) begin
            if (arr_en) runc++;
            if (runc < 5) step();
            if (!busy) runc = -1;
        end
        chk("reached_run5", runc, 5);
        rst = 1'b1;
        step();
        chk_reset_outputs("midrun_reset");
        rst = 1'b0;
        res_q.delete();
        addr_q.delete();
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (job_done) pulses++;
        end
        chk("no_job_done_after_reset", pulses, 0);
        chk("cmd_ready_post_reset", cmd_ready, 1);

        run_job(8'h11, 8'd2, 1, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
